// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped 8N1 UART transmitter with byte FIFO and registered status word.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx_io #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [4:0]  mem_wmask,
   output logic [31:0] rdata,
   output logic        tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t state, state_n;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [BW-1:0] cnt, cnt_n;
   logic [2:0] idx, idx_n;
   logic [7:0] shift, shift_n;
   logic tx_n, pop, tick, full, empty, overflow;
   logic sel, push_req, push_ok, clr_ovf, unused_bits;
`ifdef UART_TX_PARITY_EN
   logic par, par_n;
`endif
   assign sel = mem_addr[22];
   assign push_req = sel & mem_wmask[0] & mem_addr[3];
   assign clr_ovf = sel & mem_wmask[0] & mem_addr[4];
   assign full = count == CW'(FIFO_DEPTH);
   assign empty = count == '0;
   assign push_ok = push_req & (~full | pop);
   assign tick = cnt == BW'(CLKS_PER_BIT - 1);
   assign unused_bits = ^{mem_addr[31:23], mem_addr[21:5], mem_addr[2:0], mem_wdata[31:8], mem_wmask[4:1]};
   always_ff @(posedge CLK)
      if (push_ok) mem[wr_ptr] <= mem_wdata[7:0];
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
         rdata <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_ok);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + CW'(push_ok) - CW'(pop);
         // Clear first so a dropped push in the same cycle still leaves the flag set
         overflow <= (overflow & ~clr_ovf) | (push_req & full & ~pop);
         rdata <= {28'd0, empty, overflow, (state != IDLE) | ~empty, full};
      end
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         shift <= '0;
         tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         idx <= idx_n;
         shift <= shift_n;
         tx <= tx_n;
`ifdef UART_TX_PARITY_EN
         par <= par_n;
`endif
      end
   always_comb begin
      state_n = state;
      cnt_n = tick ? '0 : cnt + 1'b1;
      idx_n = idx;
      shift_n = shift;
      pop = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n = par;
`endif
      case (state)
         IDLE: begin
            cnt_n = '0;
            pop = ~empty;
            state_n = empty ? IDLE : START;
         end
         START: if (tick) begin
            state_n = DATA;
            idx_n = '0;
         end
         DATA: if (tick) begin
            shift_n = shift >> 1;
            idx_n = idx + 1'b1;
`ifdef UART_TX_PARITY_EN
            if (idx == 3'd7) state_n = PARITY;
         end
         PARITY: if (tick) state_n = STOP;
`else
            if (idx == 3'd7) state_n = STOP;
         end
`endif
         STOP: if (tick) begin
            pop = ~empty;
            state_n = empty ? IDLE : START;
         end
         default: state_n = IDLE;
      endcase
      if (pop) shift_n = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      if (pop) par_n = ^mem[rd_ptr];
      tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : (state_n == PARITY) ? par_n : 1'b1;
`else
      // tx follows the next state so the line changes on the same edge as the FSM
      tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : 1'b1;
`endif
   end
endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: directed bench for uart_tx_io with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_io;
   logic CLK = 1'b0;
   logic RESET_N = 1'b1;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [4:0] mem_wmask = '0;
   logic [31:0] rdata;
   logic tx;
   int n_checks = 0;
   int n_errors = 0;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   uart_tx_io #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .rdata(rdata), .tx(tx)
   );
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] m);
      mem_addr = a;
      mem_wdata = d;
      mem_wmask = m;
   endtask
   // Samples every cycle of one frame; call with the next negedge inside the start bit
   task automatic frame(input logic [7:0] b);
      logic [10:0] bits;
`ifdef UART_TX_PARITY_EN
      bits = {1'b1, ^b, b, 1'b0};
`else
      bits = {2'b11, b, 1'b0};
`endif
      for (int i = 0; i < NB; i++)
         for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            check($sformatf("tx_%h_bit%0d", b, i), tx, bits[i]);
            if (c == 0) check("busy", rdata[1], 1'b1);
         end
   endtask
   task automatic settle(input logic [31:0] exp_rdata);
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      check("idle_tx", tx, 1'b1);
      check("idle_rdata", rdata, exp_rdata);
   endtask
   initial begin
      int lows;
      #1 RESET_N = 1'b0;
      #1;
      check("reset_tx", tx, 1'b1);
      check("reset_rdata", rdata, 32'h0);
      repeat (2) @(posedge CLK);
      #1 RESET_N = 1'b1;
      settle(32'h8);
      fork
         begin
            drive(32'h0040_0008, 32'h0000_00A5, 5'b01111);
            @(posedge CLK);
            #1 drive(0, 0, 0);
         end
         begin
            @(posedge CLK);
            @(posedge CLK);
            frame(8'hA5);
         end
      join
      settle(32'h8);
      fork
         begin
            drive(32'h0040_0008, 32'h0000_AB55, 5'b00011);
            @(posedge CLK);
            #1 drive(32'h0040_0008, 32'hFFFF_FF0F, 5'b01111);
            @(posedge CLK);
            #1 drive(32'h0040_0008, 32'h0000_00FF, 5'b00001);
            @(posedge CLK);
            #1 drive(0, 0, 0);
         end
         begin
            @(posedge CLK);
            @(posedge CLK);
            frame(8'h55);
            frame(8'h0F);
            frame(8'hFF);
         end
      join
      settle(32'h8);
      fork
         begin
            for (int i = 1; i <= 6; i++) begin
               drive(32'h0040_0008, 32'(i * 17), 5'b00001);
               @(posedge CLK);
               #1;
            end
            drive(0, 0, 0);
            @(posedge CLK);
            @(negedge CLK);
            check("ovf_status", rdata, 32'h7);
         end
         begin
            @(posedge CLK);
            @(posedge CLK);
            for (int i = 1; i <= 5; i++) frame(8'(i * 17));
         end
      join
      settle(32'hC);
      drive(32'h0040_0010, 32'h0, 5'b00001);
      @(posedge CLK);
      #1 drive(0, 0, 0);
      @(posedge CLK);
      @(negedge CLK);
      check("ovf_clear", rdata, 32'h8);
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               drive(32'h0040_0008, 32'(8'h60 + i), 5'b00001);
               @(posedge CLK);
               #1;
            end
            drive(0, 0, 0);
            repeat (36) @(posedge CLK);
            #1 drive(32'h0040_0008, 32'h65, 5'b00001);
            @(posedge CLK);
            #1 drive(0, 0, 0);
            @(posedge CLK);
            @(negedge CLK);
            check("full_pop_status", rdata, 32'h3);
         end
         begin
            @(posedge CLK);
            @(posedge CLK);
            for (int i = 0; i < 6; i++) frame(8'(8'h60 + i));
         end
      join
      settle(32'h8);
      drive(32'h0040_0008, 32'hA5, 5'b00001);
      @(posedge CLK);
      #1 drive(0, 0, 0);
      repeat (18) @(posedge CLK);
      #2;
      check("pre_rst_tx", tx, 1'b0);
      RESET_N = 1'b0;
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_rdata", rdata, 32'h0);
      #4 RESET_N = 1'b1;
      lows = 0;
      repeat (60) begin
         @(negedge CLK);
         if (!tx) lows++;
      end
      check("no_frame_after_rst", lows, 0);
      check("rdata_after_rst", rdata, 32'h8);
      fork
         begin
            drive(32'h0040_0008, 32'h07, 5'b00001);
            @(posedge CLK);
            #1 drive(0, 0, 0);
         end
         begin
            @(posedge CLK);
            @(posedge CLK);
            frame(8'h07);
         end
      join
      settle(32'h8);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
